// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the data memory: port A has priority, a bounded
// wait counter forces a port B grant after MAX_WAIT consecutive A grants.
module dmem_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 20,
  parameter int MEM_DEPTH = 1001,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_ack,
  output logic              b_ack,
  output logic              a_err,
  output logic              b_err,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0]  WAIT_LIM = CNT_W'(MAX_WAIT);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              win_b_q, we_q, oor_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              a_ack_q, b_ack_q, a_err_q, b_err_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              memread_q, memwrite_q, busy_q;

  logic              win_b_d, we_d, oor_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  always_comb begin
    win_b_d = b_req && (!a_req || (wait_cnt_q == WAIT_LIM));
    we_d    = win_b_d ? b_we    : a_we;
    addr_d  = win_b_d ? b_addr  : a_addr;
    wdata_d = win_b_d ? b_wdata : a_wdata;
    oor_d   = ({1'b0, addr_d} >= DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      win_b_q    <= 1'b0;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!b_req) wait_cnt_q <= '0;
          if (a_req || b_req) begin
            win_b_q    <= win_b_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            oor_q      <= oor_d;
            // Strobes are registered here so they are high for exactly the ACCESS cycle.
            memread_q  <= !we_d && !oor_d;
            memwrite_q <= we_d && !oor_d;
            busy_q     <= 1'b1;
            state_q    <= S_ACCESS;
            if (win_b_d)    wait_cnt_q <= '0;
            else if (b_req) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        S_ACCESS: begin
          state_q <= S_DONE;
          if (win_b_q) begin
            b_ack_q <= 1'b1;
            b_err_q <= oor_q;
            if (oor_q)      b_rdata_q <= '0;
            else if (!we_q) b_rdata_q <= mem_read_data;
          end else begin
            a_ack_q <= 1'b1;
            a_err_q <= oor_q;
            if (oor_q)      a_rdata_q <= '0;
            else if (!we_q) a_rdata_q <= mem_read_data;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_ack             = a_ack_q;
  assign b_ack             = b_ack_q;
  assign a_err             = a_err_q;
  assign b_err             = b_err_q;
  assign a_rdata           = a_rdata_q;
  assign b_rdata           = b_rdata_q;
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;
  assign mem_memread       = memread_q;
  assign mem_memwrite      = memwrite_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, transaction-level reference memory
// and per-port expected read data, randomized traffic.
module tb_dmem_arbiter;
  localparam int AW = 20;
  localparam int DW = 20;
  localparam int DEPTH = 1001;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic a_ack, b_ack, a_err, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic mem_memread, mem_memwrite, busy;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_err(a_err), .b_err(b_err),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 14) return 20'h00001;
    return DW'((i * 32'h9E37 + 32'h5A5) ^ (i << 7));
  endfunction

  // Behavioural memory seen by the DUT; initialised on the first clock edge.
  logic [DW-1:0] mem [0:DEPTH-1];
  bit mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (mem_memwrite && (int'(mem_write_address) < DEPTH)) begin
      mem[mem_write_address[9:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = (int'(mem_read_address) < DEPTH) ? mem[mem_read_address[9:0]] : '0;

  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] exp_rd_a, exp_rd_b;
  int vectors = 0;
  int miscompares = 0;

  // Drives one request on one port and observes it until ack (bounded).
  task automatic run_one(input bit pb, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         output int lat, output int strobes, output int strobe_at,
                         output logic [AW-1:0] s_addr, output logic [DW-1:0] s_data, output bit s_we,
                         output bit other_ack, output bit err,
                         output logic [DW-1:0] rd, output logic [DW-1:0] rd_other);
    lat = -1; strobes = 0; strobe_at = -1; s_addr = '0; s_data = '0; s_we = 1'b0;
    other_ack = 1'b0; err = 1'b0; rd = '0; rd_other = '0;
    if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    for (int c = 0; c < 8 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_memread || mem_memwrite) begin
        strobes++; strobe_at = c; s_we = mem_memwrite;
        s_addr = mem_memwrite ? mem_write_address : mem_read_address;
        s_data = mem_write_data;
      end
      if (pb ? a_ack : b_ack) other_ack = 1'b1;
      if (pb ? b_ack : a_ack) begin
        lat = c;
        err = pb ? b_err : a_err;
        rd = pb ? b_rdata : a_rdata;
        rd_other = pb ? a_rdata : b_rdata;
      end
    end
    @(posedge clk); #1;
    if (pb) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic test_reset;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({a_ack, b_ack, a_err, b_err, busy, mem_memread, mem_memwrite} !== 7'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000000", {a_ack, b_ack, a_err, b_err, busy, mem_memread, mem_memwrite});
    end
    vectors++;
    if ({a_rdata, b_rdata, mem_write_data} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h/%h/%h want 0", a_rdata, b_rdata, mem_write_data);
    end
    vectors++;
    if ({mem_read_address, mem_write_address} !== '0) begin
      miscompares++; $display("FAIL reset_addr: got %h/%h want 0", mem_read_address, mem_write_address);
    end
    rst_n = 1'b1;
    exp_rd_a = '0; exp_rd_b = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    int lat, st, sat; logic [AW-1:0] sa; logic [DW-1:0] sd, rd, rdo; bit swe, oa, er;
    run_one(1'b0, 1'b1, 20'd5, 20'h00ABC, lat, st, sat, sa, sd, swe, oa, er, rd, rdo);
    ref_mem[5] = 20'h00ABC;
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL wr_latency: got %0d want 2", lat); end
    vectors++;
    if (st !== 1 || sat !== 1 || swe !== 1'b1) begin
      miscompares++; $display("FAIL wr_strobe: got count %0d at %0d we %b want 1 at 1 we 1", st, sat, swe);
    end
    vectors++;
    if (sa !== 20'd5 || sd !== 20'h00ABC) begin
      miscompares++; $display("FAIL wr_payload: got %h/%h want 00005/00abc", sa, sd);
    end
    vectors++;
    if (er !== 1'b0 || oa !== 1'b0) begin miscompares++; $display("FAIL wr_err: got err %b other_ack %b want 0 0", er, oa); end
    run_one(1'b0, 1'b0, 20'd5, 20'h0, lat, st, sat, sa, sd, swe, oa, er, rd, rdo);
    exp_rd_a = ref_mem[5];
    vectors++;
    if (lat !== 2 || rd !== 20'h00ABC) begin
      miscompares++; $display("FAIL rd_back: got lat %0d data %h want 2 00abc", lat, rd);
    end
    vectors++;
    if (st !== 1 || swe !== 1'b0 || sa !== 20'd5) begin
      miscompares++; $display("FAIL rd_strobe: got count %0d we %b addr %h want 1 0 00005", st, swe, sa);
    end
  endtask

  task automatic test_preloaded;
    int lat, st, sat; logic [AW-1:0] sa; logic [DW-1:0] sd, rd, rdo; bit swe, oa, er;
    run_one(1'b1, 1'b0, 20'd14, 20'h0, lat, st, sat, sa, sd, swe, oa, er, rd, rdo);
    exp_rd_b = 20'h00001;
    vectors++;
    if (lat !== 2 || rd !== 20'h00001 || er !== 1'b0) begin
      miscompares++; $display("FAIL preload_b: got lat %0d data %h err %b want 2 00001 0", lat, rd, er);
    end
    vectors++;
    if (oa !== 1'b0 || rdo !== exp_rd_a) begin
      miscompares++; $display("FAIL preload_a_quiet: got ack %b rdata %h want 0 %h", oa, rdo, exp_rd_a);
    end
  endtask

  task automatic test_out_of_range;
    int lat, st, sat; logic [AW-1:0] sa; logic [DW-1:0] sd, rd, rdo; bit swe, oa, er;
    run_one(1'b0, 1'b0, 20'd1001, 20'h0, lat, st, sat, sa, sd, swe, oa, er, rd, rdo);
    exp_rd_a = '0;
    vectors++;
    if (st !== 0) begin miscompares++; $display("FAIL oor_strobe: got %0d strobe cycles want 0", st); end
    vectors++;
    if (lat !== 2 || er !== 1'b1 || rd !== 20'h0) begin
      miscompares++; $display("FAIL oor_ack: got lat %0d err %b rdata %h want 2 1 00000", lat, er, rd);
    end
    run_one(1'b1, 1'b1, 20'hFFFFF, 20'h12345, lat, st, sat, sa, sd, swe, oa, er, rd, rdo);
    exp_rd_b = '0;
    vectors++;
    if (st !== 0 || lat !== 2 || er !== 1'b1 || rd !== 20'h0) begin
      miscompares++; $display("FAIL oor_write_b: got strobes %0d lat %0d err %b rdata %h want 0 2 1 00000", st, lat, er, rd);
    end
    run_one(1'b0, 1'b0, 20'd1000, 20'h0, lat, st, sat, sa, sd, swe, oa, er, rd, rdo);
    exp_rd_a = ref_mem[1000];
    vectors++;
    if (st !== 1 || er !== 1'b0 || rd !== ref_mem[1000]) begin
      miscompares++; $display("FAIL top_addr: got strobes %0d err %b rdata %h want 1 0 %h", st, er, rd, ref_mem[1000]);
    end
  endtask

  task automatic test_simultaneous;
    int ta, tb, lat, st, sat; logic [AW-1:0] sa, addr; logic [DW-1:0] sd, rd, rdo, wd, got_a; bit swe, oa, er;
    addr = 20'($urandom_range(0, DEPTH - 1));
    wd = 20'($urandom);
    ta = -1; tb = -1; got_a = '0;
    a_req = 1; a_we = 0; a_addr = addr;
    b_req = 1; b_we = 1; b_addr = addr; b_wdata = wd;
    for (int c = 0; c < 12 && (ta < 0 || tb < 0); c++) begin
      @(negedge clk);
      vectors++;
      if (a_ack && b_ack) begin miscompares++; $display("FAIL sim_dual_ack: got both acks at cycle %0d want at most one", c); end
      if (a_ack) begin ta = c; got_a = a_rdata; end
      if (b_ack) tb = c;
      @(posedge clk); #1;
      if (ta >= 0) a_req = 1'b0;
      if (tb >= 0) b_req = 1'b0;
    end
    a_req = 0; b_req = 0;
    vectors++;
    if (ta !== 2 || tb !== 5) begin miscompares++; $display("FAIL sim_order: got a@%0d b@%0d want a@2 b@5", ta, tb); end
    vectors++;
    if (got_a !== ref_mem[addr[9:0]]) begin miscompares++; $display("FAIL sim_a_data: got %h want %h", got_a, ref_mem[addr[9:0]]); end
    ref_mem[addr[9:0]] = wd;
    run_one(1'b0, 1'b0, addr, 20'h0, lat, st, sat, sa, sd, swe, oa, er, rd, rdo);
    exp_rd_a = wd;
    vectors++;
    if (rd !== wd) begin miscompares++; $display("FAIL sim_b_written: got %h want %h", rd, wd); end
  endtask

  task automatic test_starvation;
    int g, last; bit new_a, new_b, is_b, exp_b;
    logic [DW-1:0] exp_v;
    g = 0; last = -1;
    a_req = 1; a_we = 1'($urandom); a_addr = 20'($urandom_range(0, DEPTH - 1)); a_wdata = 20'($urandom);
    b_req = 1; b_we = 1'($urandom); b_addr = 20'($urandom_range(0, DEPTH - 1)); b_wdata = 20'($urandom);
    for (int c = 0; c < 300 && g < 21; c++) begin
      new_a = 0; new_b = 0;
      @(negedge clk);
      vectors++;
      if (a_ack && b_ack) begin miscompares++; $display("FAIL starve_dual_ack: got both acks at cycle %0d want at most one", c); end
      if (a_ack || b_ack) begin
        is_b = b_ack;
        exp_b = ((g % (MW + 1)) == MW) && (g < 20);
        vectors++;
        if (is_b !== exp_b) begin miscompares++; $display("FAIL starve_grant%0d: got port %s want %s", g, is_b ? "B" : "A", exp_b ? "B" : "A"); end
        vectors++;
        if ((g == 0 && c !== 2) || (g > 0 && c - last !== 3)) begin
          miscompares++; $display("FAIL starve_spacing%0d: got cycle %0d after %0d want spacing 3", g, c, last);
        end
        if (is_b) begin
          if (b_we) ref_mem[b_addr[9:0]] = b_wdata; else exp_rd_b = ref_mem[b_addr[9:0]];
          exp_v = exp_rd_b; new_b = 1;
        end else begin
          if (a_we) ref_mem[a_addr[9:0]] = a_wdata; else exp_rd_a = ref_mem[a_addr[9:0]];
          exp_v = exp_rd_a; new_a = 1;
        end
        vectors++;
        if ((is_b ? b_rdata : a_rdata) !== exp_v) begin
          miscompares++; $display("FAIL starve_rdata%0d: got %h want %h", g, is_b ? b_rdata : a_rdata, exp_v);
        end
        last = c; g++;
      end
      @(posedge clk); #1;
      if (new_a) begin
        if (g >= 21) a_req = 0;
        else begin a_we = 1'($urandom); a_addr = 20'($urandom_range(0, DEPTH - 1)); a_wdata = 20'($urandom); end
      end
      if (new_b) begin
        if (g >= 20) b_req = 0;
        else begin b_we = 1'($urandom); b_addr = 20'($urandom_range(0, DEPTH - 1)); b_wdata = 20'($urandom); end
      end
    end
    a_req = 0; b_req = 0;
    vectors++;
    if (g !== 21) begin miscompares++; $display("FAIL starve_timeout: got %0d grants want 21", g); end
  endtask

  task automatic test_random;
    int lat, st, sat; logic [AW-1:0] sa, addr; logic [DW-1:0] sd, rd, rdo, wd, exp_own, exp_oth; bit swe, oa, er, pb, we, oor;
    for (int n = 0; n < 40; n++) begin
      pb = 1'($urandom); we = 1'($urandom); wd = 20'($urandom);
      oor = ($urandom_range(0, 7) == 0);
      addr = oor ? 20'($urandom_range(DEPTH, 20'hFFFFF)) : 20'($urandom_range(0, DEPTH - 1));
      exp_oth = pb ? exp_rd_a : exp_rd_b;
      exp_own = oor ? '0 : (we ? (pb ? exp_rd_b : exp_rd_a) : ref_mem[addr[9:0]]);
      run_one(pb, we, addr, wd, lat, st, sat, sa, sd, swe, oa, er, rd, rdo);
      if (!oor && we) ref_mem[addr[9:0]] = wd;
      if (pb) exp_rd_b = exp_own; else exp_rd_a = exp_own;
      vectors++;
      if (lat !== 2 || er !== oor || rd !== exp_own) begin
        miscompares++; $display("FAIL rand%0d_resp: got lat %0d err %b rdata %h want 2 %b %h", n, lat, er, rd, oor, exp_own);
      end
      vectors++;
      if (oa !== 1'b0 || rdo !== exp_oth) begin
        miscompares++; $display("FAIL rand%0d_other: got ack %b rdata %h want 0 %h", n, oa, rdo, exp_oth);
      end
      vectors++;
      if (st !== (oor ? 0 : 1) || (!oor && (sat !== 1 || swe !== we || sa !== addr || (we && sd !== wd)))) begin
        miscompares++; $display("FAIL rand%0d_mem: got strobes %0d at %0d we %b addr %h data %h want %0d at 1 we %b addr %h data %h",
                                n, st, sat, swe, sa, sd, oor ? 0 : 1, we, addr, wd);
      end
    end
  endtask

  task automatic test_reset_in_access;
    int lat, st, sat; bit seen_ack; logic [AW-1:0] sa; logic [DW-1:0] sd, rd, rdo, old; bit swe, oa, er;
    old = ref_mem[7];
    a_req = 1; a_we = 1; a_addr = 20'd7; a_wdata = ~old;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (mem_memwrite !== 1'b1) begin miscompares++; $display("FAIL rst_pre_strobe: got %b want 1", mem_memwrite); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_memwrite, mem_memread, busy} !== 3'b000) begin
      miscompares++; $display("FAIL rst_async_drop: got %b want 000", {mem_memwrite, mem_memread, busy});
    end
    a_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    exp_rd_a = '0; exp_rd_b = '0;
    seen_ack = 0;
    repeat (4) begin @(negedge clk); if (a_ack || b_ack) seen_ack = 1; end
    vectors++;
    if (seen_ack !== 1'b0 || a_rdata !== '0) begin
      miscompares++; $display("FAIL rst_no_ack: got ack %b rdata %h want 0 00000", seen_ack, a_rdata);
    end
    @(posedge clk); #1;
    run_one(1'b0, 1'b0, 20'd7, 20'h0, lat, st, sat, sa, sd, swe, oa, er, rd, rdo);
    vectors++;
    if (rd !== old) begin miscompares++; $display("FAIL rst_no_commit: got %h want %h", rd, old); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_write_read();
    test_preloaded();
    test_out_of_range();
    test_simultaneous();
    test_starvation();
    test_random();
    test_reset_in_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
